// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM arbiter, its 16-bit clients and the 32-bit Avalon-MM controller port.
// master = arbiter view, slave = clients + controller view.
interface sdram_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 24
);
  // controller side
  logic [ADDR_W-2:0]           avm_address;
  logic [3:0]                  avm_byteenable_n;
  logic                        avm_chipselect;
  logic [31:0]                 avm_writedata;
  logic                        avm_read_n;
  logic                        avm_write_n;
  logic [31:0]                 avm_readdata;
  logic                        avm_readdatavalid;
  logic                        avm_waitrequest;
  // client side
  logic [N_CLIENTS*ADDR_W-1:0] cl_addr;
  logic [N_CLIENTS-1:0]        cl_read;
  logic [N_CLIENTS-1:0]        cl_write;
  logic [N_CLIENTS*16-1:0]     cl_writedata;
  logic [15:0]                 cl_readdata;
  logic [N_CLIENTS-1:0]        cl_done;
  logic                        cl_error;

  modport master (
    output avm_address, avm_byteenable_n, avm_chipselect, avm_writedata,
           avm_read_n, avm_write_n,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest,
    input  cl_addr, cl_read, cl_write, cl_writedata,
    output cl_readdata, cl_done, cl_error
  );

  modport slave (
    input  avm_address, avm_byteenable_n, avm_chipselect, avm_writedata,
           avm_read_n, avm_write_n,
    output avm_readdata, avm_readdatavalid, avm_waitrequest,
    output cl_addr, cl_read, cl_write, cl_writedata,
    input  cl_readdata, cl_done, cl_error
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin front end: N 16-bit clients onto one 32-bit SDRAM Avalon-MM port,
// one transaction in flight, read timeout with late-beat discard.
module sdram_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int ADDR_W    = 24,
  parameter int TIMEOUT   = 255
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  sdram_arbiter_if.master bus
);
  localparam int PTR_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  typedef struct packed {
    logic [PTR_W-1:0] g;   // granted client
    logic             rd;  // read (else write)
    logic             hi;  // upper half word of the 32-bit beat
  } txn_t;

  state_t               state;
  txn_t                 txn;
  logic [PTR_W-1:0]     rr_ptr;
  logic                 drop;
  logic [15:0]          cnt;

  logic                 gnt_vld;
  logic [PTR_W-1:0]     gnt_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic [15:0]          sel_wd;
  logic                 sel_rd;
  logic [N_CLIENTS-1:0] done_vec;

  // First requester at or after rr_ptr, scanning cyclically.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_CLIENTS) j = j - N_CLIENTS;
      if (!gnt_vld && (bus.cl_read[j] || bus.cl_write[j])) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
  end

  always_comb begin
    sel_addr = bus.cl_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_wd   = bus.cl_writedata[int'(gnt_idx)*16 +: 16];
    sel_rd   = bus.cl_read[gnt_idx];
    for (int i = 0; i < N_CLIENTS; i++)
      done_vec[i] = (txn.g == PTR_W'(i));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= IDLE;
      txn                  <= '0;
      rr_ptr               <= '0;
      drop                 <= 1'b0;
      cnt                  <= '0;
      bus.avm_address      <= '0;
      bus.avm_byteenable_n <= 4'hF;
      bus.avm_chipselect   <= 1'b0;
      bus.avm_writedata    <= '0;
      bus.avm_read_n       <= 1'b1;
      bus.avm_write_n      <= 1'b1;
      bus.cl_readdata      <= '0;
      bus.cl_done          <= '0;
      bus.cl_error         <= 1'b0;
    end else begin
      // A beat owed to a timed-out read is swallowed wherever it shows up.
      if (drop && bus.avm_readdatavalid) drop <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt_vld) begin
            txn.g                <= gnt_idx;
            txn.rd               <= sel_rd;
            txn.hi               <= sel_addr[0];
            bus.avm_address      <= sel_addr[ADDR_W-1:1];
            bus.avm_writedata    <= {sel_wd, sel_wd};
            bus.avm_byteenable_n <= sel_addr[0] ? 4'b0011 : 4'b1100;
            bus.avm_chipselect   <= 1'b1;
            bus.avm_read_n       <= !sel_rd;
            bus.avm_write_n      <= sel_rd;
            state                <= ISSUE;
          end
        end

        ISSUE: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_chipselect   <= 1'b0;
            bus.avm_read_n       <= 1'b1;
            bus.avm_write_n      <= 1'b1;
            bus.avm_byteenable_n <= 4'hF;
            cnt                  <= '0;
            if (txn.rd) begin
              state <= WAIT_RD;
            end else begin
              bus.cl_done  <= done_vec;
              bus.cl_error <= 1'b0;
              state        <= DONE;
            end
          end
        end

        WAIT_RD: begin
          cnt <= cnt + 16'd1;
          if (bus.avm_readdatavalid && !drop) begin
            bus.cl_readdata <= txn.hi ? bus.avm_readdata[31:16] : bus.avm_readdata[15:0];
            bus.cl_error    <= 1'b0;
            bus.cl_done     <= done_vec;
            state           <= DONE;
          end else if (cnt == 16'(TIMEOUT)) begin
            // The controller still owes us a beat; mark it for discard.
            drop            <= 1'b1;
            bus.cl_readdata <= '0;
            bus.cl_error    <= 1'b1;
            bus.cl_done     <= done_vec;
            state           <= DONE;
          end
        end

        DONE: begin
          bus.cl_done <= '0;
          rr_ptr      <= (txn.g == PTR_W'(N_CLIENTS-1)) ? '0 : txn.g + 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: write, stalled read, timeout + late beat,
// async reset in ISSUE, then round-robin over four clients.
module tb_sdram_arbiter;
  localparam int N  = 4;
  localparam int AW = 24;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sdram_arbiter_if #(.N_CLIENTS(N), .ADDR_W(AW)) bus ();

  sdram_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .TIMEOUT(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next completion pulse; returns 0 if none came.
  task automatic wait_done(output logic [N-1:0] got);
    got = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.cl_done != '0) begin
        got = bus.cl_done;
        break;
      end
    end
  endtask

  logic [N-1:0] got;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.cl_addr           = '0;
    bus.cl_read           = '0;
    bus.cl_write          = '0;
    bus.cl_writedata      = '0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_waitrequest   = 1'b0;
    tick();
    tick();

    check("rst read_n",     32'(bus.avm_read_n),       32'h1);
    check("rst write_n",    32'(bus.avm_write_n),      32'h1);
    check("rst chipselect", 32'(bus.avm_chipselect),   32'h0);
    check("rst byteen_n",   32'(bus.avm_byteenable_n), 32'hF);
    check("rst address",    32'(bus.avm_address),      32'h0);
    check("rst writedata",  bus.avm_writedata,         32'h0);
    check("rst cl_done",    32'(bus.cl_done),          32'h0);
    check("rst cl_error",   32'(bus.cl_error),         32'h0);
    check("rst readdata",   32'(bus.cl_readdata),      32'h0);
    rst_n = 1'b1;
    tick();

    // ---- write, client 0, odd address -> upper lanes
    bus.cl_write[0]          = 1'b1;
    bus.cl_addr[0*AW +: AW]  = 24'h000005;
    bus.cl_writedata[0 +: 16] = 16'hBEEF;
    tick();
    check("wr cs",        32'(bus.avm_chipselect),   32'h1);
    check("wr write_n",   32'(bus.avm_write_n),      32'h0);
    check("wr read_n",    32'(bus.avm_read_n),       32'h1);
    check("wr address",   32'(bus.avm_address),      32'h000002);
    check("wr byteen_n",  32'(bus.avm_byteenable_n), 32'h3);
    check("wr writedata", bus.avm_writedata,         32'hBEEFBEEF);
    check("wr no early done", 32'(bus.cl_done),      32'h0);
    tick();
    check("wr done",      32'(bus.cl_done),          32'h1);
    check("wr error",     32'(bus.cl_error),         32'h0);
    check("wr write_n 1cyc", 32'(bus.avm_write_n),   32'h1);
    check("wr byteen idle",  32'(bus.avm_byteenable_n), 32'hF);
    bus.cl_write[0] = 1'b0;
    tick();
    check("wr done pulse", 32'(bus.cl_done),         32'h0);

    // ---- read, client 2, 3 stall cycles, beat 2 cycles after acceptance
    bus.cl_read[2]          = 1'b1;
    bus.cl_addr[2*AW +: AW] = 24'h000010;
    bus.avm_waitrequest     = 1'b1;
    tick();
    check("rd cs",       32'(bus.avm_chipselect),   32'h1);
    check("rd read_n",   32'(bus.avm_read_n),       32'h0);
    check("rd address",  32'(bus.avm_address),      32'h000008);
    check("rd byteen_n", 32'(bus.avm_byteenable_n), 32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd stall hold", 32'(bus.avm_read_n),   32'h0);
    end
    bus.avm_waitrequest = 1'b0;
    tick();
    check("rd accepted read_n", 32'(bus.avm_read_n),     32'h1);
    check("rd accepted cs",     32'(bus.avm_chipselect), 32'h0);
    tick();
    check("rd wait no done", 32'(bus.cl_done), 32'h0);
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'h1234ABCD;
    tick();
    bus.avm_readdatavalid = 1'b0;
    check("rd done",     32'(bus.cl_done),     32'h4);
    check("rd data",     32'(bus.cl_readdata), 32'hABCD);
    check("rd error",    32'(bus.cl_error),    32'h0);
    bus.cl_read[2] = 1'b0;
    tick();

    // ---- timeout, client 1 (rr_ptr is now 3, wraps to 1), odd address
    bus.cl_read[1]          = 1'b1;
    bus.cl_addr[1*AW +: AW] = 24'h000021;
    tick();                                  // ISSUE
    tick();                                  // first WAIT_RD cycle
    for (int i = 0; i < 8; i++) begin
      tick();
      check("to not yet", 32'(bus.cl_done), 32'h0);
    end
    tick();                                  // WAIT_RD entry + 9
    check("to done",  32'(bus.cl_done),     32'h2);
    check("to error", 32'(bus.cl_error),    32'h1);
    check("to data",  32'(bus.cl_readdata), 32'h0);
    bus.cl_read[1] = 1'b0;
    tick();

    // next read, client 2: stale beat first (discard), then its own beat
    bus.cl_read[2]          = 1'b1;
    bus.cl_addr[2*AW +: AW] = 24'h000031;
    tick();                                  // ISSUE
    tick();                                  // WAIT_RD
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 32'hDEADBEEF;
    tick();
    check("late beat dropped", 32'(bus.cl_done), 32'h0);
    bus.avm_readdata      = 32'h5A5A0F0F;
    tick();
    bus.avm_readdatavalid = 1'b0;
    check("own beat done",  32'(bus.cl_done),     32'h4);
    check("own beat data",  32'(bus.cl_readdata), 32'h5A5A);
    check("own beat error", 32'(bus.cl_error),    32'h0);
    bus.cl_read[2] = 1'b0;
    tick();

    // ---- async reset while client 3 is stalled in ISSUE (rr_ptr is 3)
    bus.cl_read[3]          = 1'b1;
    bus.cl_addr[3*AW +: AW] = 24'h000040;
    bus.avm_waitrequest     = 1'b1;
    tick();
    check("ar in issue", 32'(bus.avm_chipselect), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar read_n", 32'(bus.avm_read_n),       32'h1);
    check("ar cs",     32'(bus.avm_chipselect),   32'h0);
    check("ar done",   32'(bus.cl_done),          32'h0);
    check("ar byteen", 32'(bus.avm_byteenable_n), 32'hF);
    bus.cl_read[3]      = 1'b0;
    bus.avm_waitrequest = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("ar no done after", 32'(bus.cl_done), 32'h0);

    // ---- round robin: all four write continuously, pointer restarts at 0
    for (int k = 0; k < N; k++) begin
      bus.cl_addr[k*AW +: AW]    = 24'(k * 2);
      bus.cl_writedata[k*16 +: 16] = 16'(16'h1000 + k);
    end
    bus.cl_write = '1;
    for (int n = 0; n < 5; n++) begin
      wait_done(got);
      check($sformatf("rr grant %0d", n), 32'(got), 32'(4'b0001 << (n % N)));
    end
    bus.cl_write = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
